// File: rtl/alu_arbiter_pkg.sv
// Shared opcodes, FSM encoding and constant result patterns for the
// two-requester ALU arbiter.
package alu_arbiter_pkg;

  typedef enum logic [2:0] {
    OP_ADD      = 3'd0,
    OP_APB      = 3'd1,
    OP_NOR_NAND = 3'd2,
    OP_ANY      = 3'd3,
    OP_POP      = 3'd4,
    OP_SWAPINV  = 3'd5,
    OP_XOR_XNOR = 3'd6,
    OP_ZERO     = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [7:0] PAT_ANY = 8'hC0;
  localparam logic [7:0] PAT_POP = 8'h3F;

  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Requester-side bus of the ALU arbiter: requests, operands, grant/done/result.
interface alu_arbiter_if #(
  parameter int OPW = 3,
  parameter int DW  = 4
);
  logic [1:0]      req;
  logic [DW-1:0]   a0, b0, a1, b1;
  logic [OPW-1:0]  op0, op1;
  logic [1:0]      gnt;
  logic [1:0]      done;
  logic [2*DW-1:0] result;
  logic            busy;

  modport master (
    output req, a0, b0, a1, b1, op0, op1,
    input  gnt, done, result, busy
  );

  modport slave (
    input  req, a0, b0, a1, b1, op0, op1,
    output gnt, done, result, busy
  );
endinterface

// File: rtl/alu_core.sv
// Combinational ALU: two DW-bit operands and an opcode -> 2*DW-bit result.
module alu_core
  import alu_arbiter_pkg::*;
#(
  parameter int OPW = 3,
  parameter int DW  = 4
) (
  input  logic [DW-1:0]   a,
  input  logic [DW-1:0]   b,
  input  logic [OPW-1:0]  op,
  output logic [2*DW-1:0] y
);
  logic [DW:0]   c;
  logic [DW-1:0] s;
  alu_op_e       opc;

  assign opc  = alu_op_e'(3'(op));
  assign c[0] = 1'b0;

  // Explicit ripple chain so the carry out lands in bit DW of the sum.
  for (genvar i = 0; i < DW; i++) begin : g_rca
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  always_comb begin
    y = '0;
    case (opc)
      OP_ADD, OP_APB: y = (2*DW)'({c[DW], s});
      OP_NOR_NAND:    y = {~(a | b), ~(a & b)};
      OP_ANY:         y = ((|a) || (|b)) ? (2*DW)'(PAT_ANY) : '0;
      OP_POP:         y = ($countones(a) == 2 && $countones(b) == 3) ? (2*DW)'(PAT_POP) : '0;
      OP_SWAPINV:     y = {b, ~a};
      OP_XOR_XNOR:    y = {a ^ b, a ~^ b};
      default:        y = '0;
    endcase
  end
endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter for two requesters sharing one ALU; IDLE/EXEC/DONE
// sequence gives one operation every three cycles.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int OPW = 3,
  parameter int DW  = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_arbiter_if.slave  bus
);
  state_e          state, nxt;
  logic            pick, win, last;
  logic [DW-1:0]   la, lb;
  logic [OPW-1:0]  lop;
  logic [2*DW-1:0] alu_y;

  // On a tie the requester not served last wins; a lone request wins outright.
  assign pick     = (bus.req == 2'b11) ? ~last : bus.req[1];
  assign bus.busy = (state != IDLE);

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (|bus.req) nxt = EXEC;
      EXEC:    nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win        <= 1'b0;
      last       <= 1'b1;
      la         <= '0;
      lb         <= '0;
      lop        <= '0;
      bus.gnt    <= '0;
      bus.done   <= '0;
      bus.result <= '0;
    end else begin
      case (state)
        IDLE: if (|bus.req) begin
          win     <= pick;
          la      <= pick ? bus.a1  : bus.a0;
          lb      <= pick ? bus.b1  : bus.b0;
          lop     <= pick ? bus.op1 : bus.op0;
          bus.gnt <= onehot2(pick);
        end
        EXEC: begin
          bus.result <= alu_y;
          bus.done   <= onehot2(win);
        end
        DONE: begin
          bus.done <= '0;
          bus.gnt  <= '0;
          last     <= win;
        end
        default: begin
          bus.done <= '0;
          bus.gnt  <= '0;
        end
      endcase
    end
  end

  alu_core #(.OPW(OPW), .DW(DW)) u_alu (
    .a  (la),
    .b  (lb),
    .op (lop),
    .y  (alu_y)
  );
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a transaction-timeline reference model.
module tb_alu_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  alu_arbiter_if #(.OPW(3), .DW(4)) bus ();
  alu_arbiter #(.OPW(3), .DW(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  function automatic logic [7:0] ref_alu(input logic [3:0] a, input logic [3:0] b,
                                         input logic [2:0] op);
    case (op)
      3'd0, 3'd1: return {3'b000, {1'b0, a} + {1'b0, b}};
      3'd2:       return {~(a | b), ~(a & b)};
      3'd3:       return (a != 0 || b != 0) ? 8'hC0 : 8'h00;
      3'd4:       return ($countones(a) == 2 && $countones(b) == 3) ? 8'h3F : 8'h00;
      3'd5:       return {b, ~a};
      3'd6:       return {a ^ b, ~(a ^ b)};
      default:    return 8'h00;
    endcase
  endfunction

  // Model: an accepted request at edge s grants for edges s..s+1, completes
  // after edge s+1, and frees the ALU at edge s+2.
  int         cyc = 0;
  int         s   = 0;
  bit         active = 1'b0;
  bit         win    = 1'b0;
  bit         last   = 1'b1;
  logic [3:0] ma = '0, mb = '0;
  logic [2:0] mop = '0;
  logic [7:0] m_result = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active   = 1'b0;
      last     = 1'b1;
      m_result = 8'h00;
    end else begin
      cyc++;
      if (active && cyc == s + 1) m_result = ref_alu(ma, mb, mop);
      else if (active && cyc == s + 2) begin
        active = 1'b0;
        last   = win;
      end else if (!active && bus.req != 2'b00) begin
        win    = (bus.req == 2'b11) ? !last : bus.req[1];
        ma     = win ? bus.a1  : bus.a0;
        mb     = win ? bus.b1  : bus.b0;
        mop    = win ? bus.op1 : bus.op0;
        s      = cyc;
        active = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    logic [1:0] eg, ed;
    eg = active ? (win ? 2'b10 : 2'b01) : 2'b00;
    ed = (active && cyc == s + 1) ? eg : 2'b00;
    total++;
    if (bus.gnt !== eg || bus.done !== ed || bus.result !== m_result || bus.busy !== active) begin
      bad++;
      $display("FAIL model t=%0t: gnt=%b done=%b result=%h busy=%b want gnt=%b done=%b result=%h busy=%b",
               $time, bus.gnt, bus.done, bus.result, bus.busy, eg, ed, m_result, active);
    end
    if (bus.done != 2'b00 && bus.done !== bus.gnt) begin
      total++;
      bad++;
      $display("FAIL done_gnt t=%0t: done=%b gnt=%b want equal", $time, bus.done, bus.gnt);
    end
  end

  task automatic check(input string nm, input logic [15:0] got, input logic [15:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.req = 2'b00;
    repeat (2) @(negedge clk);
    check("reset_out", {5'd0, bus.gnt, bus.done, bus.result, bus.busy}, 16'h0000);
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  // Waits at negedges for a done pulse, checks who and what, optionally drops req.
  task automatic wait_done(input int idx, input logic [7:0] want, input string nm,
                           input bit drop, output int at);
    int n = 0;
    @(negedge clk);
    while (bus.done == 2'b00 && n < 12) begin
      @(negedge clk);
      n++;
    end
    at = cyc;
    check({nm, "_done"}, {14'd0, bus.done}, (idx == 1) ? 16'h0002 : 16'h0001);
    check({nm, "_res"},  {8'd0, bus.result}, {8'd0, want});
    if (drop) begin
      @(posedge clk);
      #2 bus.req[idx] = 1'b0;
    end
  endtask

  task automatic do_op(input int idx, input logic [3:0] a, input logic [3:0] b,
                       input logic [2:0] op, input logic [7:0] want, input string nm);
    int at;
    if (idx == 1) begin bus.a1 = a; bus.b1 = b; bus.op1 = op; end
    else          begin bus.a0 = a; bus.b0 = b; bus.op0 = op; end
    bus.req[idx] = 1'b1;
    wait_done(idx, want, nm, 1'b1, at);
  endtask

  initial begin
    int at, prev;
    bus.req = 2'b00;
    bus.a0 = '0; bus.b0 = '0; bus.op0 = '0;
    bus.a1 = '0; bus.b1 = '0; bus.op1 = '0;
    do_reset();

    // Basic add with timing of grant and done.
    bus.a0 = 4'h3; bus.b0 = 4'h5; bus.op0 = 3'd0; bus.req = 2'b01;
    @(negedge clk);
    check("add_pre_gnt", {14'd0, bus.gnt}, 16'h0000);
    @(negedge clk);
    check("add_gnt",  {14'd0, bus.gnt, bus.done}, 16'h0004);
    @(negedge clk);
    check("add_done", {6'd0, bus.gnt, bus.done, bus.result}, 16'h0508);
    @(posedge clk);
    #2 bus.req = 2'b00;

    // Tie from reset: requester 0 first.
    do_reset();
    bus.a0 = 4'hA; bus.b0 = 4'h5; bus.op0 = 3'd6;
    bus.a1 = 4'h1; bus.b1 = 4'h9; bus.op1 = 3'd5;
    bus.req = 2'b11;
    wait_done(0, 8'hF0, "tie_r0", 1'b1, at);
    wait_done(1, 8'h9E, "tie_r1", 1'b1, at);

    do_op(0, 4'b0011, 4'b0111, 3'd4, 8'h3F, "pop_yes");
    do_op(0, 4'b0111, 4'b0111, 3'd4, 8'h00, "pop_no");
    do_op(0, 4'h0, 4'h0, 3'd3, 8'h00, "any_zero");
    do_op(1, 4'h0, 4'h1, 3'd3, 8'hC0, "any_set");
    do_op(0, 4'h3, 4'h5, 3'd2, 8'h8E, "nor_nand");
    do_op(1, 4'hF, 4'hF, 3'd1, 8'h1E, "apb_carry");
    do_op(0, 4'h6, 4'h9, 3'd7, 8'h00, "zero");

    // In-flight operation ignores later operand/opcode changes and req drop.
    bus.a0 = 4'h9; bus.b0 = 4'h8; bus.op0 = 3'd0; bus.req = 2'b01;
    @(negedge clk);
    @(negedge clk);
    check("hold_gnt", {14'd0, bus.gnt}, 16'h0001);
    #1 begin bus.a0 = 4'h0; bus.op0 = 3'd7; bus.req = 2'b00; end
    wait_done(0, 8'h11, "hold", 1'b0, at);
    prev = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.done != 2'b00) prev++;
    end
    check("hold_once", 16'(prev), 16'h0000);

    // Reset during EXEC discards the operation.
    bus.a0 = 4'h2; bus.b0 = 4'h2; bus.op0 = 3'd5; bus.req = 2'b01;
    @(negedge clk);
    @(negedge clk);
    check("rst_mid_gnt", {14'd0, bus.gnt}, 16'h0001);
    #1 begin rst_n = 1'b0; bus.req = 2'b00; end
    #1 check("rst_mid_out", {5'd0, bus.gnt, bus.done, bus.result, bus.busy}, 16'h0000);
    @(posedge clk);
    #2 rst_n = 1'b1;
    prev = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.done != 2'b00) prev++;
    end
    check("rst_no_done", 16'(prev), 16'h0000);
    do_op(1, 4'h2, 4'h3, 3'd0, 8'h05, "post_rst");

    // Continuous tie: alternating grants, done every 3 cycles.
    do_reset();
    bus.a0 = 4'h1; bus.b0 = 4'h2; bus.op0 = 3'd0;
    bus.a1 = 4'h4; bus.b1 = 4'h4; bus.op1 = 3'd6;
    bus.req = 2'b11;
    prev = -1;
    for (int k = 0; k < 6; k++) begin
      wait_done(k % 2, (k % 2) ? 8'h0F : 8'h03, $sformatf("rr%0d", k), 1'b0, at);
      if (prev >= 0) check($sformatf("rr_gap%0d", k), 16'(at - prev), 16'd3);
      prev = at;
    end
    @(posedge clk);
    #2 bus.req = 2'b00;
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, want finish before 200000");
    $fatal(1);
  end
endmodule
